// File: rtl/dst_reg_pipe.sv
// dst_reg_pipe: selects a destination register index from NUM_IN candidates, pipes it with a valid bit through DEPTH stages (stall/flush, async active-high rst_i), and compares src_i against every stage for hazard/forwarding; define ZERO_SUPPRESS_EN to never track or match register 0
module dst_reg_pipe #(
  parameter int WIDTH = 5,
  parameter int NUM_IN = 3,
  parameter int DEPTH = 3,
  localparam int SEL_W = ($clog2(NUM_IN) > 1) ? $clog2(NUM_IN) : 1,
  localparam int STG_W = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_IN*WIDTH-1:0] data_i,
  input  logic [SEL_W-1:0]        select_i,
  input  logic                    valid_i,
  input  logic                    stall_i,
  input  logic                    flush_i,
  input  logic [WIDTH-1:0]        src_i,
  output logic [DEPTH*WIDTH-1:0]  data_o,
  output logic [DEPTH-1:0]        valid_o,
  output logic [DEPTH-1:0]        match_o,
  output logic                    hit_o,
  output logic [STG_W-1:0]        hit_stage_o
);
  logic [WIDTH-1:0] sel_data;
  logic             sel_ok;
  logic             sel_valid;
  logic [WIDTH-1:0] stg_data [DEPTH];
  logic [DEPTH-1:0] stg_valid;
  always_comb begin
    sel_data = '0;
    sel_ok = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (select_i == SEL_W'(k)) begin
        sel_data = data_i[k*WIDTH +: WIDTH];
        sel_ok = 1'b1;
      end
    end
  end
`ifdef ZERO_SUPPRESS_EN
  assign sel_valid = sel_ok && valid_i && (|sel_data);
`else
  assign sel_valid = sel_ok && valid_i;
`endif
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int d = 0; d < DEPTH; d++) stg_data[d] <= '0;
      stg_valid <= '0;
    end else begin
      if (flush_i) begin
        stg_data[0] <= '0;
        stg_valid[0] <= 1'b0;
      end else if (!stall_i) begin
        stg_data[0] <= sel_data;
        stg_valid[0] <= sel_valid;
      end
      if (!stall_i) begin
        for (int d = 1; d < DEPTH; d++) begin
          stg_data[d] <= stg_data[d-1];
          stg_valid[d] <= stg_valid[d-1];
        end
      end
    end
  end
  for (genvar d = 0; d < DEPTH; d++) begin : g_stage
    assign data_o[d*WIDTH +: WIDTH] = stg_data[d];
`ifdef ZERO_SUPPRESS_EN
    assign match_o[d] = stg_valid[d] && (stg_data[d] == src_i) && (|src_i);
`else
    assign match_o[d] = stg_valid[d] && (stg_data[d] == src_i);
`endif
  end
  assign valid_o = stg_valid;
  assign hit_o = |match_o;
  always_comb begin
    hit_stage_o = '0;
    for (int d = DEPTH - 1; d >= 0; d--) hit_stage_o = match_o[d] ? STG_W'(d) : hit_stage_o;
  end
endmodule

// File: doc/dst_reg_pipe.md
# dst_reg_pipe

Parametrised successor to the two-input destination-register mux. It selects the write-destination register index from NUM_IN candidates, such as Rt, Rd and the link register. It then carries the selected index and a valid bit through a DEPTH-stage pipeline with stall and flush. Each cycle it compares a source index against every in-flight stage and reports matches for hazard detection and forwarding. It sits between decode and the hazard/forwarding units of the CPU pipeline.

## Interface
Parameters (derived constants: SEL_W = max(1, clog2(NUM_IN)), STG_W = max(1, clog2(DEPTH))):
- WIDTH, 5, bit width of a register index
- NUM_IN, 3, number of candidate indices (≥2)
- DEPTH, 3, number of pipeline stages (≥1)

Ports:
- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  reset, asynchronous, active-high
- data_i  input  NUM_IN*WIDTH  packed candidates; candidate k at bits [k*WIDTH +: WIDTH]
- select_i  input  SEL_W  candidate select
- valid_i  input  1  current instruction writes a register
- stall_i  input  1  hold all stages except as noted for flush
- flush_i  input  1  insert a bubble into stage 0
- src_i  input  WIDTH  source index to compare
- data_o  output  DEPTH*WIDTH  stage d index at bits [d*WIDTH +: WIDTH]; stage 0 is youngest
- valid_o  output  DEPTH  per-stage valid
- match_o  output  DEPTH  per-stage compare result
- hit_o  output  1  any stage matches
- hit_stage_o  output  STG_W  lowest (youngest) matching stage

## Operation
Selection (combinational):
- When select_i < NUM_IN, sel_data = candidate[select_i] and sel_valid = valid_i.
- When select_i ≥ NUM_IN, sel_data = 0 and sel_valid = 0.

Pipeline update, per rising edge when not in reset:
- Stage 0:
  - flush_i=1: loads data 0, valid 0. This applies regardless of stall_i.
  - Else stall_i=1: holds.
  - Else: loads sel_data and sel_valid.
- Stage d>0:
  - stall_i=1: holds.
  - Else: loads stage d-1 data and valid.
- Stall and flush together: stage 0 is cleared and the other stages hold. The bubble then occupies stage 0.
- Stalls and flushes do not drop any valid entry except the one deliberately killed at stage 0.

Compare (combinational on current outputs and src_i):
- match_o[d] = valid_o[d] AND (stage d data == src_i).
- hit_o = OR of match_o.
- hit_stage_o = smallest d with match_o[d]=1; 0 when hit_o=0.

Reset:
- All stage data = 0 and all valid_o = 0, asynchronously, while rst_i=1.
- Consequently match_o = 0, hit_o = 0 and hit_stage_o = 0.
- Reset asserted mid-stream discards all in-flight entries. The first capture occurs on the first rising edge after rst_i falls.

## Timing
- A candidate presented before edge n appears in stage 0 after edge n, and in stage d after edge n+d, with no stalls.
- Each stall cycle adds one cycle of latency to every held stage.
- match_o, hit_o and hit_stage_o are purely combinational from registered state and src_i, with zero added latency.
- No combinational path exists from data_i, select_i, valid_i, stall_i or flush_i to any output.

## Configuration
ZERO_SUPPRESS_EN:
- Defined:
  - Any selected index equal to 0 enters stage 0 with valid 0.
  - src_i == 0 forces match_o to 0, so writes to register 0 never create hazards.
- Undefined:
  - Index 0 is tracked and compared like any other index.

## Test plan
- Reset: assert rst_i mid-stream with valid entries in all stages -> valid_o=0 and data_o=0 immediately (before the next clock edge); hit_o=0.
- Select/propagate: data_i={31,12,7} (k=2,1,0), select_i=1, valid_i=1, no stall -> stage 0 = 12 after edge 1 and stage 2 = 12 after edge 3; select_i=3 -> stage 0 valid 0, data 0.
- Stall/flush:
  - Fill stages with 5, 6, 7 and hold stall_i=1 for 2 cycles -> contents unchanged.
  - Then stall_i=1, flush_i=1 for 1 cycle -> stage 0 valid 0, stages 1–2 unchanged.
- Compare priority: stages hold {9,9,4} (d=0,1,2), all valid, src_i=9 -> match_o=3'b011, hit_o=1, hit_stage_o=0; src_i=4 -> hit_stage_o=2; src_i=1 -> hit_o=0.
- Invalid entry: stage 1 holds 9 with valid 0, src_i=9 -> match_o[1]=0.
- Zero index: select an index of 0 with valid_i=1, then src_i=0:
  - With ZERO_SUPPRESS_EN -> valid_o[0]=0 and hit_o=0.
  - Without it -> valid_o[0]=1, match_o[0]=1, hit_o=1.
